uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// 8E1 UART transmitter: start, 8 data bits LSB first, even parity, one stop bit.
// Bit timing comes from a 16x oversampling tick derived from CLK_HZ and the latched baud code.
module uart_transmitter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    // Divisors are round(CLK_HZ / (16 * baud)), folded to constants at elaboration.
    localparam int DIV_300    = (CLK_HZ + 8 * 300)    / (16 * 300);
    localparam int DIV_1200   = (CLK_HZ + 8 * 1200)   / (16 * 1200);
    localparam int DIV_4800   = (CLK_HZ + 8 * 4800)   / (16 * 4800);
    localparam int DIV_9600   = (CLK_HZ + 8 * 9600)   / (16 * 9600);
    localparam int DIV_19200  = (CLK_HZ + 8 * 19200)  / (16 * 19200);
    localparam int DIV_38400  = (CLK_HZ + 8 * 38400)  / (16 * 38400);
    localparam int DIV_57600  = (CLK_HZ + 8 * 57600)  / (16 * 57600);
    localparam int DIV_115200 = (CLK_HZ + 8 * 115200) / (16 * 115200);
    localparam int DIV_W      = $clog2(DIV_300 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic [2:0]       baud_q, baud_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] div_last;
    logic             accept;
    logic             bit_end;

    always_comb begin
        div_last = DIV_W'(DIV_300 - 1);
        case (baud_q)
            3'b000:  div_last = DIV_W'(DIV_300 - 1);
            3'b001:  div_last = DIV_W'(DIV_1200 - 1);
            3'b010:  div_last = DIV_W'(DIV_4800 - 1);
            3'b011:  div_last = DIV_W'(DIV_9600 - 1);
            3'b100:  div_last = DIV_W'(DIV_19200 - 1);
            3'b101:  div_last = DIV_W'(DIV_38400 - 1);
            3'b110:  div_last = DIV_W'(DIV_57600 - 1);
            default: div_last = DIV_W'(DIV_115200 - 1);
        endcase
    end

    assign accept  = Tx_WR && Tx_EN && !busy_q;
    assign bit_end = (div_cnt_q == div_last) && (tick_cnt_q == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            baud_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            baud_q     <= baud_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        baud_d     = baud_q;

        if (state_q == IDLE) begin
            if (accept) begin
                state_d    = START;
                data_d     = Tx_DATA;
                baud_d     = baud_select;
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                bit_idx_d  = '0;
            end
        end else begin
            // Tick and bit counters run free inside a frame, so bit edges never drift.
            if (div_cnt_q == div_last) begin
                div_cnt_d  = '0;
                tick_cnt_d = tick_cnt_q + 4'd1;
            end else begin
                div_cnt_d  = div_cnt_q + DIV_W'(1);
            end

            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                    DATA: begin
                        if (bit_idx_q == 3'd7) begin
                            state_d = PARITY;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                    PARITY:  state_d = STOP;
                    STOP:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Outputs are computed from the next state so TxD and Tx_BUSY come straight off flops.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bit_end;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_d[bit_idx_d];
            PARITY:  txd_d = ^data_d;
            default: txd_d = 1'b1;
        endcase
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;
    assign Tx_DONE = done_q;

endmodule
